combo_tx: RTL and testbench
===========================

COMBO_TX -- requirements
Module: combo_tx

Interface
REQ-001 Parameter CODE_W, default 5, number of combination bits shifted out.
REQ-002 Parameter TMO_CYC, default 16, maximum cycles to wait for ready or for a verdict.
REQ-003 clock  input  1  free-running clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to send a combination.
REQ-006 code  input  CODE_W  combination, sent MSB first.
REQ-007 ready  input  1  lock ready for combination.
REQ-008 unlock  input  1  lock reports unlocked.
REQ-009 error  input  1  lock reports error in combination.
REQ-010 x  output  1  serial combination bit to the lock.
REQ-011 busy  output  1  high while a transaction is in progress.
REQ-012 done  output  1  one-cycle pulse at transaction end.
REQ-013 pass  output  1  last transaction unlocked; valid from done until next accepted start.
REQ-014 fail  output  1  last transaction got error or timed out; same validity as pass.
REQ-015 tmo  output  1  fail was caused by timeout; same validity as pass.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT_RDY, SEND, HOLD, RELEASE, FIN.
REQ-017 The block SHALL accept start only in IDLE, latch code and enter WAIT_RDY; start in any other state SHALL be ignored.
REQ-018 On acceptance, pass, fail and tmo SHALL clear and busy SHALL rise on the next edge.
REQ-019 WAIT_RDY: x=0; on ready=1 enter SEND; after TMO_CYC cycles without ready, set fail and tmo, then enter FIN.
REQ-020 SEND: x SHALL be registered and present one code bit per cycle, MSB first, so bit k is driven in the k-th cycle after leaving WAIT_RDY.
REQ-021 error=1 during SEND SHALL abort shifting, set fail and enter RELEASE on the next edge.
REQ-022 After the LSB cycle the block SHALL enter HOLD, keeping x at the LSB value.
REQ-023 HOLD: unlock=1 sets pass; error=1 sets fail; either enters RELEASE; after TMO_CYC cycles with neither, set fail and tmo, then enter RELEASE.
REQ-024 If unlock and error are both high in one cycle, error SHALL win.
REQ-025 RELEASE: x=0 until ready=1, then enter FIN; RELEASE SHALL have no timeout.
REQ-026 FIN: done=1 for exactly one cycle, busy falls, return to IDLE.
REQ-027 pass and fail SHALL never be high together.
REQ-028 The timeout counter SHALL be ceil(log2(TMO_CYC+1)) bits, clear on every state change and saturate rather than wrap.

Reset
REQ-029 Reset SHALL force IDLE and x=0, busy=0, done=0, pass=0, fail=0, tmo=0, and clear the counter and latched code.
REQ-030 Reset asserted mid-transaction SHALL abort it with no done pulse.

Configuration
REQ-031 Macro COMBO_TX_RETRY_EN defined: an error verdict (not a timeout) on the first attempt SHALL pass through RELEASE, then re-enter SEND once when ready=1, resending the latched code, with done only after the second attempt.
REQ-032 COMBO_TX_RETRY_EN undefined: an error SHALL end the transaction after RELEASE as in REQ-021/REQ-023.

Structure
REQ-033 Package combo_pkg SHALL hold the FSM state enum and the default CODE_W and TMO_CYC constants, shared with the lock.
REQ-034 The timeout counter SHALL be a sub-module combo_timer (inputs clear and enable, output expired).

Verification
REQ-035 code=5'b10101, lock ready -> x sequence 1,0,1,0,1; unlock; x=0; ready; done with pass=1, fail=0.
REQ-036 code=5'b10110 -> error on 4th bit; shifting stops; x=0 until ready; done with fail=1, tmo=0.
REQ-037 ready held 0 -> done exactly TMO_CYC+2 cycles after start, fail=1, tmo=1, x never 1.
REQ-038 start pulsed again during SEND -> ignored; transmitted bits and the single done unchanged.
REQ-039 reset pulsed mid-SEND -> x=0 and busy=0 immediately; no done; next start works normally.
REQ-040 With COMBO_TX_RETRY_EN, first attempt errors and second unlocks -> two SEND bursts, one done, pass=1.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared definitions for the combination transmitter and the lock it drives:
// FSM state encoding, default geometry and the timeout counter width helper.
package combo_pkg;

  localparam int unsigned COMBO_CODE_W  = 5;
  localparam int unsigned COMBO_TMO_CYC = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SEND,
    ST_HOLD,
    ST_RELEASE,
    ST_FIN
  } combo_state_e;

  // Bits needed to hold the value tmo without wrapping.
  function automatic int unsigned tmr_width(input int unsigned tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/combo_tx_if.sv
// Host/lock-side signal bundle for combo_tx; slave is the transmitter view.
interface combo_tx_if
  import combo_pkg::*;
#(
  parameter int unsigned CODE_W = COMBO_CODE_W
);

  logic              start;
  logic [CODE_W-1:0] code;
  logic              ready;
  logic              unlock;
  logic              error;
  logic              x;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              tmo;

  modport master (
    output start, code, ready, unlock, error,
    input  x, busy, done, pass, fail, tmo
  );

  modport slave (
    input  start, code, ready, unlock, error,
    output x, busy, done, pass, fail, tmo
  );

endinterface

// File: rtl/combo_timer.sv
// Saturating wait-cycle counter; expired holds once TMO_CYC cycles have been counted.
module combo_timer
  import combo_pkg::*;
#(
  parameter int unsigned TMO_CYC = COMBO_TMO_CYC
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW    = tmr_width(TMO_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TMO_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/combo_tx.sv
// Serial combination transmitter: waits for the lock, shifts the code MSB first,
// collects the verdict and releases. Optional macro: COMBO_TX_RETRY_EN (one resend on error).
module combo_tx
  import combo_pkg::*;
#(
  parameter int unsigned CODE_W  = COMBO_CODE_W,
  parameter int unsigned TMO_CYC = COMBO_TMO_CYC
) (
  input logic       clock,
  input logic       reset,
  combo_tx_if.slave bus
);

  localparam int unsigned   IW   = $clog2(CODE_W + 1);
  localparam logic [IW-1:0] LAST = IW'(CODE_W - 1);

  combo_state_e      state_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] sh_q;
  logic [IW-1:0]     idx_q;
  logic              x_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_q;
  logic              tmo_q;
  logic              tmr_en;
  logic              tmr_clr;
  logic              expired;
`ifdef COMBO_TX_RETRY_EN
  logic              retried_q;
`endif

  // Only WAIT_RDY and HOLD are timed, and each is entered from an untimed
  // state, so holding the counter clear elsewhere clears it on every change.
  assign tmr_en  = (state_q == ST_WAIT_RDY) || (state_q == ST_HOLD);
  assign tmr_clr = ~tmr_en;

  combo_timer #(
    .TMO_CYC (TMO_CYC)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      x_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef COMBO_TX_RETRY_EN
      retried_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            code_q    <= bus.code;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b1;
`ifdef COMBO_TX_RETRY_EN
            retried_q <= 1'b0;
`endif
            state_q   <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (bus.ready) begin
            x_q     <= code_q[CODE_W-1];
            sh_q    <= code_q << 1;
            idx_q   <= '0;
            state_q <= ST_SEND;
          end else if (expired) begin
            fail_q  <= 1'b1;
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_SEND: begin
          if (bus.error) begin
            fail_q  <= 1'b1;
            x_q     <= 1'b0;
            state_q <= ST_RELEASE;
          end else if (idx_q == LAST) begin
            state_q <= ST_HOLD;
          end else begin
            x_q   <= sh_q[CODE_W-1];
            sh_q  <= sh_q << 1;
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.error) begin
            fail_q <= 1'b1;
          end else if (bus.unlock) begin
            pass_q <= 1'b1;
          end else if (expired) begin
            fail_q <= 1'b1;
            tmo_q  <= 1'b1;
          end
          if (bus.error || bus.unlock || expired) begin
            x_q     <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (bus.ready) begin
`ifdef COMBO_TX_RETRY_EN
            if (fail_q && !tmo_q && !retried_q) begin
              retried_q <= 1'b1;
              fail_q    <= 1'b0;
              x_q       <= code_q[CODE_W-1];
              sh_q      <= code_q << 1;
              idx_q     <= '0;
              state_q   <= ST_SEND;
            end else
`endif
            begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.x    = x_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
  assign bus.tmo  = tmo_q;

endmodule

// File: tb/tb_combo_tx.sv
// Randomized bench for combo_tx: a transaction-level lock model expands each
// scenario into per-cycle lock inputs and expected transmitter outputs.
module tb_combo_tx;
  import combo_pkg::*;

  localparam int unsigned W   = COMBO_CODE_W;
  localparam int unsigned TMO = 8;

  typedef struct {
    bit           st;
    logic [W-1:0] cd;
    bit           rdy, unl, err;
    bit           ex, eb, ed;
    bit           chk;
    bit           ep, ef, et;
  } cyc_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  cyc_t q[$];

  combo_tx_if #(.CODE_W(W)) bus ();

  combo_tx #(
    .CODE_W  (W),
    .TMO_CYC (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  function automatic bit nz();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.cd = W'($urandom);
    return c;
  endfunction

  // Expand one transaction into cycles. Ready/verdict delays count idle cycles
  // spent in that phase; a phase with no answer lasts TMO+1 cycles.
  task automatic build(input logic [W-1:0] cd, input int rdy_wait, input int err_bit,
                       input int vkind, input int vdelay, input int rel_wait, input int gap);
    cyc_t c;
    bit   p = 0, f = 0, t = 0, again = 1;
    int   att = 0, eb_ = err_bit, vk = vkind, vd = vdelay;
    c = blank(); c.st = 1; c.cd = cd; q.push_back(c);
    for (int w = 0; ; w++) begin
      c = blank(); c.eb = 1; c.rdy = (w >= rdy_wait); c.unl = nz(); c.err = nz(); c.st = nz();
      if (w == 0) c.chk = 1;
      q.push_back(c);
      if (c.rdy) break;
      if (w == int'(TMO)) begin f = 1; t = 1; break; end
    end
    while (!t && again) begin
      again = 0;
      for (int k = 0; k < int'(W); k++) begin
        c = blank(); c.eb = 1; c.ex = cd[int'(W) - 1 - k]; c.err = (k == eb_);
        c.rdy = nz(); c.st = nz();
        q.push_back(c);
        if (c.err) break;
      end
      if (eb_ >= 0) f = 1;
      else begin
        for (int h = 0; ; h++) begin
          c = blank(); c.eb = 1; c.ex = cd[0]; c.rdy = nz(); c.st = nz();
          if (h == vd && vk != 0) begin c.unl = (vk & 1) != 0; c.err = (vk & 2) != 0; end
          q.push_back(c);
          if (h == vd && vk != 0) begin
            if ((vk & 2) != 0) f = 1; else p = 1;
            break;
          end
          if (h == int'(TMO)) begin f = 1; t = 1; break; end
        end
      end
      for (int r = 0; r <= rel_wait; r++) begin
        c = blank(); c.eb = 1; c.rdy = (r == rel_wait); c.unl = nz(); c.err = nz(); c.st = nz();
        q.push_back(c);
      end
`ifdef COMBO_TX_RETRY_EN
      if (f && !t && att == 0) begin
        att = 1; again = 1; f = 0; eb_ = -1; vk = 1; vd = $urandom_range(0, 3);
      end
`endif
    end
    c = blank(); c.eb = 1; c.ed = 1; c.chk = 1; c.ep = p; c.ef = f; c.et = t;
    q.push_back(c);
    for (int g = 0; g < gap; g++) begin
      c = blank(); c.rdy = nz(); c.unl = nz(); c.err = nz(); c.chk = 1;
      c.ep = p; c.ef = f; c.et = t;
      q.push_back(c);
    end
  endtask

  task automatic play_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      bus.start = c.st; bus.code = c.cd; bus.ready = c.rdy; bus.unlock = c.unl; bus.error = c.err;
      check("x", 32'(bus.x), 32'(c.ex));
      check("busy", 32'(bus.busy), 32'(c.eb));
      check("done", 32'(bus.done), 32'(c.ed));
      if (c.chk) begin
        check("pass", 32'(bus.pass), 32'(c.ep));
        check("fail", 32'(bus.fail), 32'(c.ef));
        check("tmo", 32'(bus.tmo), 32'(c.et));
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic play();
    play_n(q.size());
  endtask

  task automatic idle_in();
    bus.start = 0; bus.code = '0; bus.ready = 0; bus.unlock = 0; bus.error = 0;
  endtask

  initial begin
    logic [W-1:0] cd;
    idle_in();
    repeat (3) @(posedge clock);
    #1;
    check("rst_x", 32'(bus.x), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_pass", 32'(bus.pass), 0);
    check("rst_fail", 32'(bus.fail), 0);
    check("rst_tmo", 32'(bus.tmo), 0);
    reset = 0;
    @(posedge clock); #1;

    cd = 5'b10101; build(cd, 0, -1, 1, 2, 1, 1);        // unlock path
    cd = 5'b10110; build(cd, 0, 3, 0, 0, 2, 1);         // error on 4th bit
    cd = W'($urandom); build(cd, TMO + 4, -1, 1, 0, 0, 1); // no ready: timeout
    cd = W'($urandom); build(cd, 2, -1, 0, 0, 1, 0);   // no verdict: hold timeout
    cd = W'($urandom); build(cd, 1, -1, 3, 1, 0, 0);   // unlock+error together
    cd = W'($urandom); build(cd, int'(TMO), -1, 1, int'(TMO), 0, 1); // last-cycle answers
    cd = W'($urandom); build(cd, 0, 0, 0, 0, 0, 1);    // error on MSB
    cd = W'($urandom); build(cd, 0, int'(W) - 1, 0, 0, 3, 2); // error on LSB
    play();

    // Reset during SEND: start, one WAIT cycle, two SEND cycles, then reset.
    cd = W'($urandom); build(cd, 0, -1, 1, 0, 0, 0);
    play_n(4);
    #2 reset = 1;
    #1;
    check("rst_mid_x", 32'(bus.x), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    q.delete();
    idle_in();
    #1 reset = 0;
    repeat (4) begin
      @(posedge clock); #1;
      check("rst_mid_done", 32'(bus.done), 0);
      check("rst_mid_idle", 32'(bus.busy), 0);
    end

    for (int n = 0; n < 40; n++) begin
      cd = W'($urandom);
      build(cd, $urandom_range(0, TMO + 2),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1,
            $urandom_range(0, 3), $urandom_range(0, TMO + 2),
            $urandom_range(0, 3), $urandom_range(0, 2));
      play();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
